// File: rtl/pattern_sequencer_multi.sv
// Multi-channel pattern sequencer: CHANNELS voices share one synchronous pattern ROM
// through a round-robin arbiter; each voice decodes NOTE / END / JUMP words.
module pattern_sequencer_multi #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [CHANNELS-1:0]        i_start,
  input  logic [CHANNELS*ADDR_W-1:0] i_start_addr,
  input  logic [CHANNELS-1:0]        i_note_stb,
  output logic [CHANNELS-1:0]        o_note_valid,
  output logic [CHANNELS*6-1:0]      o_note_pitch,
  output logic [CHANNELS*5-1:0]      o_note_len,
  output logic [CHANNELS*4-1:0]      o_note_instrument,
  output logic [CHANNELS-1:0]        o_busy,
  output logic [CHANNELS-1:0]        o_done,
  output logic [ADDR_W-1:0]          o_rom_addr,
  input  logic [15:0]                i_rom_data,
  output logic [CHANNELS*2-1:0]      o_dbg_state,
  output logic [CHANNELS*ADDR_W-1:0] o_dbg_ptr
);

  // Handshake: i_note_stb is a one-cycle request honoured only in WAIT (never queued);
  // each accepted request ends in exactly one o_note_valid or o_done pulse unless an
  // i_start or reset intervenes. There is no back-pressure on the outputs.

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_PEND  = 2'd2,
    S_FETCH = 2'd3
  } ch_state_t;

  ch_state_t           state_q [CHANNELS];
  ch_state_t           state_d [CHANNELS];
  logic [ADDR_W-1:0]   ptr_q   [CHANNELS];
  logic [ADDR_W-1:0]   ptr_d   [CHANNELS];
  logic [CHANNELS-1:0] note_ld;
  logic [CHANNELS-1:0] done_d;
  logic [CH_W-1:0]     rr_q;
  logic [CH_W-1:0]     gnt_ch;
  logic                gnt_vld;
  logic                word_is_note;
  logic                word_is_jump;

  assign word_is_note = ~i_rom_data[15];
  assign word_is_jump = i_rom_data[15] & i_rom_data[14];

  // Round-robin search starting at rr_q, which always points just past the last grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!gnt_vld && state_q[(int'(rr_q) + k) % CHANNELS] == S_PEND) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'((int'(rr_q) + k) % CHANNELS);
      end
    end
  end

  assign o_rom_addr = gnt_vld ? ptr_q[gnt_ch] : '0;

  // A channel sits in FETCH for exactly the one cycle its ROM word is on i_rom_data,
  // so the FETCH state itself is the response tag for that channel.
  always_comb begin
    note_ld = '0;
    done_d  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      ptr_d[c]   = ptr_q[c];
      if (i_start[c]) begin
        state_d[c] = S_WAIT;
        ptr_d[c]   = i_start_addr[c*ADDR_W +: ADDR_W];
      end else begin
        case (state_q[c])
          S_IDLE: ;
          S_WAIT: if (i_note_stb[c]) state_d[c] = S_PEND;
          S_PEND: if (gnt_vld && int'(gnt_ch) == c) state_d[c] = S_FETCH;
          S_FETCH: begin
            if (word_is_note) begin
              note_ld[c] = 1'b1;
              ptr_d[c]   = ptr_q[c] + ADDR_W'(1);
              state_d[c] = S_WAIT;
            end else if (word_is_jump) begin
              ptr_d[c]   = i_rom_data[ADDR_W-1:0];
              state_d[c] = S_PEND;
            end else begin
              done_d[c]  = 1'b1;
              state_d[c] = S_IDLE;
            end
          end
          default: state_d[c] = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= S_IDLE;
        ptr_q[c]   <= '0;
      end
      rr_q              <= '0;
      o_note_valid      <= '0;
      o_done            <= '0;
      o_note_pitch      <= '0;
      o_note_len        <= '0;
      o_note_instrument <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        ptr_q[c]   <= ptr_d[c];
        if (note_ld[c]) begin
          o_note_pitch[c*6 +: 6]      <= i_rom_data[14:9];
          o_note_len[c*5 +: 5]        <= i_rom_data[8:4];
          o_note_instrument[c*4 +: 4] <= i_rom_data[3:0];
        end
      end
      if (gnt_vld) begin
        rr_q <= (int'(gnt_ch) == CHANNELS - 1) ? '0 : CH_W'(int'(gnt_ch) + 1);
      end
      o_note_valid <= note_ld;
      o_done       <= done_d;
    end
  end

  always_comb begin
    o_busy      = '0;
    o_dbg_state = '0;
    o_dbg_ptr   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      o_busy[c]                      = (state_q[c] != S_IDLE);
      o_dbg_state[c*2 +: 2]          = state_q[c];
      o_dbg_ptr[c*ADDR_W +: ADDR_W]  = ptr_q[c];
    end
  end

endmodule

// File: tb/tb_pattern_sequencer_multi.sv
// Bench for pattern_sequencer_multi: directed scenarios, then randomized patterns checked
// against a pattern-walking reference model with an expected-note queue.
module tb_pattern_sequencer_multi;

  localparam int CHANNELS = 4;
  localparam int ADDR_W   = 8;
  localparam int DEPTH    = 1 << ADDR_W;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [CHANNELS-1:0]        start = '0;
  logic [CHANNELS*ADDR_W-1:0] start_addr = '0;
  logic [CHANNELS-1:0]        note_stb = '0;
  logic [CHANNELS-1:0]        note_valid;
  logic [CHANNELS*6-1:0]      pitch;
  logic [CHANNELS*5-1:0]      len;
  logic [CHANNELS*4-1:0]      instr;
  logic [CHANNELS-1:0]        busy;
  logic [CHANNELS-1:0]        done;
  logic [ADDR_W-1:0]          rom_addr;
  logic [15:0]                rom_data;
  logic [CHANNELS*2-1:0]      dbg_state;
  logic [CHANNELS*ADDR_W-1:0] dbg_ptr;

  logic [15:0] rom [DEPTH];

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // scoreboard state: entry = {channel[3:0], expected ROM word[15:0]}
  logic [19:0]         exp_q[$];
  logic [CHANNELS-1:0] outstanding;
  logic [CHANNELS-1:0] need_start;
  int                  scyc [CHANNELS];
  int                  bnd  [CHANNELS];
  int                  vcyc [CHANNELS];
  logic [ADDR_W-1:0]   mptr [CHANNELS];
  logic [15:0]         w;
  logic [ADDR_W-1:0]   p;
  logic [ADDR_W-1:0]   a;
  logic [ADDR_W-1:0]   base;
  int                  idx, j, lat, cnt, bad, vcnt, r;
  logic [1:0]          ev;

  pattern_sequencer_multi #(.CHANNELS(CHANNELS), .ADDR_W(ADDR_W)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_start           (start),
    .i_start_addr      (start_addr),
    .i_note_stb        (note_stb),
    .o_note_valid      (note_valid),
    .o_note_pitch      (pitch),
    .o_note_len        (len),
    .o_note_instrument (instr),
    .o_busy            (busy),
    .o_done            (done),
    .o_rom_addr        (rom_addr),
    .i_rom_data        (rom_data),
    .o_dbg_state       (dbg_state),
    .o_dbg_ptr         (dbg_ptr)
  );

  // ---------------- clock / reset / ROM ----------------
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_note(input string tag, input int c, input logic [15:0] word);
    check({tag, "_pitch"}, 32'(pitch[c*6 +: 6]), 32'(word[14:9]));
    check({tag, "_len"},   32'(len[c*5 +: 5]),   32'(word[8:4]));
    check({tag, "_instr"}, 32'(instr[c*4 +: 4]), 32'(word[3:0]));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    start    = '0;
    note_stb = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_ch(input int c, input logic [ADDR_W-1:0] addr);
    start_addr[c*ADDR_W +: ADDR_W] = addr;
    start[c] = 1'b1;
    tick();
    start[c] = 1'b0;
  endtask

  // ev: 1 = note valid, 2 = done, 0 = nothing within the limit; lat counts cycles after the strobe
  task automatic strobe_and_wait(input int c, input int limit, output int lat_o, output logic [1:0] ev_o);
    note_stb[c] = 1'b1;
    tick();
    note_stb[c] = 1'b0;
    lat_o = 1;
    ev_o  = 2'd0;
    while (lat_o <= limit) begin
      if (note_valid[c]) begin ev_o = 2'd1; break; end
      if (done[c])       begin ev_o = 2'd2; break; end
      tick();
      lat_o++;
    end
  endtask

  function automatic logic [ADDR_W-1:0] ptr_of(input int c);
    return dbg_ptr[c*ADDR_W +: ADDR_W];
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = {1'b0, 15'($urandom)};
    rom[8'h00] = 16'h3E7B;
    rom[8'h10] = 16'h1A35;
    rom[8'h11] = 16'h2C96;
    rom[8'h1F] = 16'h2B47;
    rom[8'h20] = 16'hC020;
    rom[8'h21] = 16'h8000;
    rom[8'h30] = 16'h8000;

    // reset state
    tick();
    check("rst_valid", 32'(note_valid), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_addr",  32'(rom_addr), 0);
    check("rst_pitch", 32'(pitch), 0);
    check("rst_len",   32'(len), 0);
    check("rst_instr", 32'(instr), 0);
    tick();
    rst = 1'b0;

    // single note on channel 0, uncontended latency 3
    start_ch(0, 8'h10);
    check("t1_busy", 32'(busy[0]), 1);
    note_stb[0] = 1'b1;
    tick();
    note_stb[0] = 1'b0;
    check("t1_addr_c1", 32'(rom_addr), 32'h10);
    check("t1_valid_c1", 32'(note_valid[0]), 0);
    tick();
    check("t1_valid_c2", 32'(note_valid[0]), 0);
    tick();
    check("t1_valid_c3", 32'(note_valid[0]), 1);
    check("t1_pitch", 32'(pitch[5:0]), 32'h0D);
    check("t1_len",   32'(len[4:0]), 32'h03);
    check("t1_instr", 32'(instr[3:0]), 32'h5);
    check("t1_ptr",   32'(ptr_of(0)), 32'h11);
    tick();
    check("t1_valid_pulse", 32'(note_valid[0]), 0);
    check("t1_pitch_hold", 32'(pitch[5:0]), 32'h0D);

    // channel 1: note then a JUMP-to-self loop
    start_ch(1, 8'h1F);
    strobe_and_wait(1, 8, lat, ev);
    check("t2_note_ev", 32'(ev), 1);
    check("t2_note_lat", lat, 3);
    check_note("t2_note", 1, rom[8'h1F]);
    note_stb[1] = 1'b1;
    tick();
    note_stb[1] = 1'b0;
    cnt = 0; bad = 0; vcnt = 0;
    for (int t = 0; t < 20; t++) begin
      if (rom_addr == 8'h20) cnt++;
      else if (rom_addr != 8'h00) bad++;
      vcnt += int'(note_valid[1]) + int'(done[1]);
      note_stb[1] = (t == 6);
      tick();
    end
    note_stb[1] = 1'b0;
    check("t2_loop_grants", 32'(cnt >= 8), 1);
    check("t2_bad_addr", bad, 0);
    check("t2_no_valid", vcnt, 0);
    check("t2_busy", 32'(busy[1]), 1);
    check("t2_ptr", 32'(ptr_of(1)), 32'h20);
    strobe_and_wait(0, 3 + CHANNELS, lat, ev);
    check("t2_c0_ev", 32'(ev), 1);
    check("t2_c0_lat", 32'(lat <= 3 + CHANNELS), 1);
    check_note("t2_c0", 0, rom[8'h11]);
    start_ch(1, 8'h1F);
    tick();

    // END word on channel 2
    start_ch(2, 8'h30);
    note_stb[2] = 1'b1;
    tick();
    note_stb[2] = 1'b0;
    tick();
    check("t3_done_c2", 32'(done[2]), 0);
    check("t3_busy_c2", 32'(busy[2]), 1);
    tick();
    check("t3_done_c3", 32'(done[2]), 1);
    check("t3_busy_c3", 32'(busy[2]), 0);
    check("t3_valid_c3", 32'(note_valid[2]), 0);
    tick();
    check("t3_done_pulse", 32'(done[2]), 0);
    note_stb[2] = 1'b1;
    tick();
    note_stb[2] = 1'b0;
    cnt = 0;
    repeat (5) begin
      cnt += int'(note_valid[2]) + int'(done[2]) + int'(busy[2]) + int'(rom_addr != 8'h00);
      tick();
    end
    check("t3_idle_ignores_stb", cnt, 0);

    // all four channels strobed together, twice
    do_reset();
    start_addr = {8'h70, 8'h60, 8'h50, 8'h40};
    start = '1;
    tick();
    start = '0;
    for (int round = 0; round < 2; round++) begin
      note_stb = '1;
      tick();
      note_stb = '0;
      for (int c = 0; c < CHANNELS; c++) vcyc[c] = 0;
      for (int t = 1; t <= 8; t++) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (note_valid[c] && vcyc[c] == 0) begin
            vcyc[c] = t;
            check_note($sformatf("t4_r%0d_ch%0d", round, c), c, rom[8'h40 + c*16 + round]);
          end
        end
        tick();
      end
      for (int c = 0; c < CHANNELS; c++)
        check($sformatf("t4_r%0d_cycle_ch%0d", round, c), vcyc[c], 3 + c);
    end

    // start collides with the returning fetch on channel 0
    note_stb[0] = 1'b1;
    tick();
    note_stb[0] = 1'b0;
    tick();
    start_addr[0 +: ADDR_W] = 8'h90;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("t5_no_valid", 32'(note_valid[0]), 0);
    check("t5_ptr", 32'(ptr_of(0)), 32'h90);
    check("t5_state_wait", 32'(dbg_state[1:0]), 1);
    check("t5_pitch_hold", 32'(pitch[5:0]), 32'(rom[8'h41][14:9]));
    note_stb[0] = 1'b1;
    tick();
    note_stb[0] = 1'b0;
    check("t5_addr", 32'(rom_addr), 32'h90);
    tick();
    tick();
    check("t5_valid", 32'(note_valid[0]), 1);
    check_note("t5_note", 0, rom[8'h90]);

    // pointer wrap 0xFF -> 0x00
    start_ch(3, 8'hFF);
    strobe_and_wait(3, 8, lat, ev);
    check("t6_ev", 32'(ev), 1);
    check("t6_lat", lat, 3);
    check("t6_ptr_wrap", 32'(ptr_of(3)), 0);
    note_stb[3] = 1'b1;
    tick();
    note_stb[3] = 1'b0;
    check("t6_addr", 32'(rom_addr), 0);
    tick();
    check("t6_state_fetch", 32'(dbg_state[7:6]), 3);
    tick();
    check("t6_valid", 32'(note_valid[3]), 1);
    check_note("t6_note", 3, rom[8'h00]);

    // asynchronous reset in the middle of a fetch
    note_stb[1] = 1'b1;
    tick();
    note_stb[1] = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("t7_valid", 32'(note_valid), 0);
    check("t7_busy",  32'(busy), 0);
    check("t7_done",  32'(done), 0);
    check("t7_addr",  32'(rom_addr), 0);
    check("t7_pitch", 32'(pitch), 0);
    check("t7_len",   32'(len), 0);
    check("t7_instr", 32'(instr), 0);
    tick();
    rst = 1'b0;
    cnt = 0;
    repeat (6) begin
      tick();
      cnt += $countones(note_valid) + $countones(done);
    end
    check("t7_no_valid_after", cnt, 0);

    // randomized patterns: notes, forward JUMPs, ENDs
    do_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      base = ADDR_W'(128 + c*32);
      for (int i = 0; i < 32; i++) begin
        r = $urandom_range(0, 9);
        if (i == 31 || r == 9 || (r >= 7 && i >= 30))
          rom[base + ADDR_W'(i)] = {2'b10, 14'($urandom)};
        else if (r >= 7)
          rom[base + ADDR_W'(i)] = {2'b11, 6'($urandom), base + ADDR_W'($urandom_range(i + 1, 31))};
        else
          rom[base + ADDR_W'(i)] = {1'b0, 15'($urandom)};
      end
    end
    exp_q.delete();
    outstanding = '0;
    need_start  = '1;
    for (int n = 0; n < 3200; n++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (note_valid[c] || done[c]) begin
          idx = -1;
          foreach (exp_q[i]) if (idx < 0 && int'(exp_q[i][19:16]) == c) idx = i;
          check($sformatf("rnd_expected_ch%0d", c), 32'(idx >= 0), 1);
          if (idx >= 0) begin
            w = exp_q[idx][15:0];
            exp_q.delete(idx);
            check($sformatf("rnd_kind_ch%0d", c), 32'({note_valid[c], done[c]}), w[15] ? 32'd1 : 32'd2);
            if (!w[15]) check_note($sformatf("rnd_ch%0d", c), c, w);
            check($sformatf("rnd_lat_ch%0d", c), 32'((cycle - scyc[c]) <= bnd[c]), 1);
            outstanding[c] = 1'b0;
            if (w[15]) need_start[c] = 1'b1;
          end
        end else if (outstanding[c] && (cycle - scyc[c]) > bnd[c]) begin
          check($sformatf("rnd_timeout_ch%0d", c), cycle - scyc[c], bnd[c]);
          idx = -1;
          foreach (exp_q[i]) if (idx < 0 && int'(exp_q[i][19:16]) == c) idx = i;
          if (idx >= 0) exp_q.delete(idx);
          outstanding[c] = 1'b0;
          need_start[c]  = 1'b1;
        end
      end
      start    = '0;
      note_stb = '0;
      if (n < 3000) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (need_start[c]) begin
            a = ADDR_W'(128 + c*32 + $urandom_range(0, 30));
            start_addr[c*ADDR_W +: ADDR_W] = a;
            start[c]      = 1'b1;
            mptr[c]       = a;
            need_start[c] = 1'b0;
          end else if (!outstanding[c] && $urandom_range(0, 2) != 0) begin
            p = mptr[c];
            j = 0;
            w = rom[p];
            while (w[15] && w[14] && j < 64) begin
              p = w[ADDR_W-1:0];
              j++;
              w = rom[p];
            end
            if (!w[15]) mptr[c] = p + ADDR_W'(1);
            exp_q.push_back({4'(c), w});
            outstanding[c] = 1'b1;
            scyc[c]        = cycle;
            bnd[c]         = 3 + 2*j + (j + 1)*(CHANNELS - 1);
            note_stb[c]    = 1'b1;
          end
        end
      end
      tick();
    end
    start    = '0;
    note_stb = '0;
    check("rnd_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
